// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-stage program loader.
//   state_t        : loader FSM encoding (3 bits)
//   IDX_W          : width of the byte-lane index within a word
//   BYTES_PER_WORD : bytes assembled per memory word
package program_loader_pkg;

  localparam int unsigned IDX_W          = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian word assembler: shifts bytes in MSB first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear of byte index and shift register
//   shift      : accept byte_in this cycle
//   byte_in    : stream byte
//   word_c     : word formed by the stored bytes plus byte_in (valid with full_c)
//   full_c     : this shift completes a word
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_c,
  output logic        full_c
);

  // Only the first three bytes need storage; the fourth arrives with full_c.
  logic [23:0]      shreg;
  logic [IDX_W-1:0] idx;

  assign word_c = {shreg, byte_in};
  assign full_c = shift && (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Shift register and byte-lane index; index wraps naturally after lane 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (shift) begin
      shreg <= {shreg[15:0], byte_in};
      idx   <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-stage program loader: receives a length header, big-endian payload
// words and an XOR checksum over a valid/ready byte stream, writes the words
// to memory from BASE_ADDR and releases the CPU once the checksum matches.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : begin a load from IDLE/DONE/ERR
//   byte_in, byte_valid  : input byte stream
//   byte_ready           : loader accepts a byte this cycle (registered)
//   mem_addr/data/we     : memory write port, one-cycle we pulse per word
//   cpu_run              : CPU released and owns memory
//   done, error          : load outcome levels
//   words_loaded         : words written in the current load
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic             mem_we,
  output logic             cpu_run,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           state;
  logic [7:0]       len_hi;
  logic [CNT_W-1:0] count;
  logic [7:0]       csum;

  logic             xfer;
  logic             load_c;
  logic             shift;
  logic [CNT_W-1:0] len_c;
  logic [31:0]      word_c;
  logic             full_c;

  assign xfer   = byte_valid && byte_ready;
  assign load_c = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign shift  = xfer && (state == S_DATA);
  assign len_c  = CNT_W'({len_hi, byte_in});

  program_loader_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (load_c),
    .shift   (shift),
    .byte_in (byte_in),
    .word_c  (word_c),
    .full_c  (full_c)
  );

  // Loader FSM; byte_ready is set on entry to each byte-accepting state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      byte_ready   <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      count        <= '0;
      csum         <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_c) begin
            state        <= S_LEN_HI;
            byte_ready   <= 1'b1;
            cpu_run      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            count        <= '0;
            csum         <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_in;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            count <= len_c;
            if (len_c > MAX_CNT) begin
              state      <= S_ERR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
            end else if (len_c == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ byte_in;
            if (full_c) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_data   <= word_c;
              mem_addr   <= BASE_ADDR + (32'(words_loaded) << 2);
            end
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + CNT_W'(1);
          byte_ready   <= 1'b1;
          state        <= ((words_loaded + CNT_W'(1)) == count) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  localparam int unsigned CNT_W = 16;
  localparam logic [7:0] GOOD_CSUM = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^
                                     8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h67;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic             mem_we;
  logic             cpu_run;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (1024),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .cpu_run      (cpu_run),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Record memory writes; the loader must never accept bytes while writing.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Two-word stream: 00 02 DEADBEEF 01234567 <cs>.
  task automatic run_stream(input logic [7:0] cs, input int gap_max, input bit poke_start);
    logic [7:0] bytes [10];
    bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i], int'($urandom_range(0, gap_max)));
      if (poke_start && i == 4) pulse_start();
    end
    send_byte(cs, int'($urandom_range(0, gap_max)));
    @(negedge clk);
  endtask

  task automatic verify_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, wr_data[0], 32'hDEAD_BEEF);
      check({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, wr_data[1], 32'h0123_4567);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 32'({byte_ready, mem_we, cpu_run, done, error}), 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_data"}, mem_data, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Asynchronous reset in the middle of the first word.
    pulse_start();
    check("start_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    check("mid_data_ready", 32'(byte_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_write_after_reset", 32'(wr_addr.size()), 32'd0);

    // Clean load after reset.
    pulse_start();
    run_stream(GOOD_CSUM, 0, 1'b0);
    verify_writes("normal");
    check("normal_done", 32'(done), 32'd1);
    check("normal_run", 32'(cpu_run), 32'd1);
    check("normal_err", 32'(error), 32'd0);
    check("normal_words", 32'(words_loaded), 32'd2);
    check("normal_ready", 32'(byte_ready), 32'd0);

    // Bad checksum: writes stay issued, load ends in error.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_run", 32'(cpu_run), 32'd0);
    check("restart_words", 32'(words_loaded), 32'd0);
    run_stream(GOOD_CSUM ^ 8'h01, 0, 1'b0);
    verify_writes("badcs");
    check("badcs_err", 32'(error), 32'd1);
    check("badcs_done", 32'(done), 32'd0);
    check("badcs_run", 32'(cpu_run), 32'd0);

    // Zero count from ERR.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("restart_err", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_run", 32'(cpu_run), 32'd1);
    check("zero_words", 32'(words_loaded), 32'd0);
    check("zero_nwrites", 32'(wr_addr.size()), 32'd0);

    // Oversize header 0x0401 > 1024.
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("over_err", 32'(error), 32'd1);
    check("over_ready", 32'(byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("over_ready_hold", 32'(byte_ready), 32'd0);

    // Header exactly 1024 is accepted; abandon via reset.
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    check("max_err", 32'(error), 32'd0);
    check("max_ready", 32'(byte_ready), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First load to reach DONE, then backpressured reload from DONE with
    // an ignored mid-load start.
    pulse_start();
    run_stream(GOOD_CSUM, 0, 1'b0);
    check("pre_bp_done", 32'(done), 32'd1);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("bp_clear_done", 32'(done), 32'd0);
    check("bp_clear_run", 32'(cpu_run), 32'd0);
    run_stream(GOOD_CSUM, 3, 1'b1);
    verify_writes("bp");
    check("bp_done", 32'(done), 32'd1);
    check("bp_run", 32'(cpu_run), 32'd1);
    check("bp_words", 32'(words_loaded), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
